// File: rtl/lfsr_draw_gen.sv
// lfsr_draw_gen: parametrised Galois LFSR with async reset, enable, seed load,
// zero-state lockup protection and a draw request/valid interface.
// Optional macro LFSR_PERIOD_CHECK_EN adds the period_wrap output together with
// a step counter and a start-state register.
module lfsr_draw_gen #(
    parameter int unsigned       WIDTH        = 13,
    parameter logic [WIDTH-1:0]  TAPS         = WIDTH'(13'h001B),
    parameter logic [WIDTH-1:0]  SEED_DEFAULT = '1,
    parameter int unsigned       OUT_BITS     = 8,
    parameter int unsigned       DRAW_STEPS   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed,
    input  logic                draw_req,
    output logic                draw_busy,
    output logic                draw_valid,
    output logic [OUT_BITS-1:0] draw_value,
    output logic [WIDTH-1:0]    lfsr_out,
    output logic                lockup
`ifdef LFSR_PERIOD_CHECK_EN
    ,
    output logic                period_wrap
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SPIN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] CNT_INIT = 8'(DRAW_STEPS - 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       state;
    logic [7:0]       cnt;
    logic             seed_zero;
    logic             state_zero;
    logic             step;

    // Galois step, seed substitution and the single-step-per-cycle enable
    always_comb begin
        next_s     = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
        seed_zero  = (seed == '0);
        state_zero = (s == '0);
        load_val   = seed_zero ? SEED_DEFAULT : seed;
        step       = !load && !state_zero && (en || (state == SPIN));
    end

    // LFSR register: load beats corruption guard beats stepping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= SEED_DEFAULT;
        end else if (load) begin
            s <= load_val;
        end else if (state_zero) begin
            s <= SEED_DEFAULT;
        end else if (step) begin
            s <= next_s;
        end
    end

    // One-cycle lockup pulse for each zero substitution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockup <= 1'b0;
        end else begin
            lockup <= load ? seed_zero : state_zero;
        end
    end

    // Draw FSM: a load aborts any draw in flight without touching draw_value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            draw_value <= '0;
        end else if (load) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (draw_req) begin
                        state <= SPIN;
                        cnt   <= CNT_INIT;
                    end
                end
                SPIN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        draw_value <= next_s[OUT_BITS-1:0];
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from registered state
    always_comb begin
        draw_busy  = (state != IDLE);
        draw_valid = (state == DONE);
        lfsr_out   = s;
    end

`ifdef LFSR_PERIOD_CHECK_EN
    logic [WIDTH-1:0] start_s;
    logic [WIDTH-1:0] period_cnt;

    // Period monitor: counts steps since the last start-state capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_s     <= SEED_DEFAULT;
            period_cnt  <= '0;
            period_wrap <= 1'b0;
        end else begin
            period_wrap <= 1'b0;
            if (load) begin
                start_s    <= load_val;
                period_cnt <= '0;
            end else if (step) begin
                if (next_s == start_s) begin
                    period_wrap <= 1'b1;
                    period_cnt  <= '0;
                end else begin
                    period_cnt <= period_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_draw_gen.sv
// Self-checking bench for lfsr_draw_gen (default parameters).
// Expected draw values are pushed to a scoreboard queue when a draw is
// requested and popped when draw_valid is observed.
module tb_lfsr_draw_gen;

    localparam int unsigned WIDTH = 13;
    localparam int unsigned OUT_BITS = 8;
    localparam int unsigned DRAW_STEPS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                load;
    logic [WIDTH-1:0]    seed;
    logic                draw_req;
    logic                draw_busy;
    logic                draw_valid;
    logic [OUT_BITS-1:0] draw_value;
    logic [WIDTH-1:0]    lfsr_out;
    logic                lockup;
`ifdef LFSR_PERIOD_CHECK_EN
    logic                period_wrap;
`endif

    int checks = 0;
    int failures = 0;
    logic [OUT_BITS-1:0] sb[$];

    lfsr_draw_gen #(
        .WIDTH(WIDTH),
        .TAPS(13'h001B),
        .SEED_DEFAULT(13'h1FFF),
        .OUT_BITS(OUT_BITS),
        .DRAW_STEPS(DRAW_STEPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load(load),
        .seed(seed),
        .draw_req(draw_req),
        .draw_busy(draw_busy),
        .draw_valid(draw_valid),
        .draw_value(draw_value),
        .lfsr_out(lfsr_out),
        .lockup(lockup)
`ifdef LFSR_PERIOD_CHECK_EN
        ,
        .period_wrap(period_wrap)
`endif
    );

    always #5 clk = ~clk;

    // Reference Galois step for x^13+x^4+x^3+x+1
    function automatic logic [WIDTH-1:0] model_step(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = {v[WIDTH-2:0], 1'b0};
        if (v[WIDTH-1]) r = r ^ 13'h001B;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; seed = '0; draw_req = 1'b0;
        tick(); tick();
        checks++; if (lfsr_out !== 13'h1FFF) begin failures++; $display("FAIL reset_lfsr got=%h exp=1fff", lfsr_out); end
        checks++; if (draw_busy !== 1'b0 || draw_valid !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b valid=%b exp=0/0", draw_busy, draw_valid); end
        checks++; if (draw_value !== 8'h00 || lockup !== 1'b0) begin failures++; $display("FAIL reset_value value=%h lockup=%b exp=00/0", draw_value, lockup); end
        rst = 1'b0;
        tick();
        checks++; if (lfsr_out !== 13'h1FFF) begin failures++; $display("FAIL idle_hold got=%h exp=1fff", lfsr_out); end
    endtask

    task automatic test_free_run();
        logic [WIDTH-1:0] exp_s;
        exp_s = 13'h1FFF;
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_s = model_step(exp_s);
            checks++; if (lfsr_out !== exp_s) begin failures++; $display("FAIL free_run_%0d got=%h exp=%h", i, lfsr_out, exp_s); end
            checks++; if (lockup !== 1'b0) begin failures++; $display("FAIL free_run_lockup_%0d got=%b exp=0", i, lockup); end
        end
        checks++; if (exp_s !== 13'h1FD1) begin failures++; $display("FAIL model_ref got=%h exp=1fd1", exp_s); end
        en = 1'b0;
    endtask

    task automatic test_load_lockup();
        load = 1'b1; seed = 13'h0000;
        tick();
        load = 1'b0;
        checks++; if (lfsr_out !== 13'h1FFF) begin failures++; $display("FAIL zero_seed_sub got=%h exp=1fff", lfsr_out); end
        checks++; if (lockup !== 1'b1) begin failures++; $display("FAIL lockup_pulse got=%b exp=1", lockup); end
        tick();
        checks++; if (lockup !== 1'b0) begin failures++; $display("FAIL lockup_width got=%b exp=0", lockup); end
        load = 1'b1; seed = 13'h0001;
        tick();
        load = 1'b0;
        checks++; if (lfsr_out !== 13'h0001 || lockup !== 1'b0) begin failures++; $display("FAIL load_seed got=%h lockup=%b exp=0001/0", lfsr_out, lockup); end
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++; if (lfsr_out !== 13'h0002) begin failures++; $display("FAIL load_then_step got=%h exp=0002", lfsr_out); end
        tick();
        checks++; if (lfsr_out !== 13'h0002) begin failures++; $display("FAIL en_low_hold got=%h exp=0002", lfsr_out); end
    endtask

    task automatic test_draw();
        logic [WIDTH-1:0] m;
        int busy_n;
        int valid_n;
        int valid_at;
        load = 1'b1; seed = 13'h0001;
        tick();
        load = 1'b0;
        m = 13'h0001;
        for (int i = 0; i < int'(DRAW_STEPS); i++) m = model_step(m);
        sb.push_back(m[OUT_BITS-1:0]);
        m = 13'h0001;
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        busy_n = draw_busy ? 1 : 0;
        valid_n = 0;
        valid_at = -1;
        checks++; if (lfsr_out !== 13'h0001) begin failures++; $display("FAIL draw_no_step_at_req got=%h exp=0001", lfsr_out); end
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i <= int'(DRAW_STEPS)) begin
                m = model_step(m);
                checks++; if (lfsr_out !== m) begin failures++; $display("FAIL draw_spin_%0d got=%h exp=%h", i, lfsr_out, m); end
            end
            if (draw_busy) busy_n++;
            if (draw_valid) begin
                valid_n++;
                valid_at = i;
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL draw_unexpected_valid at=%0d exp=none", i); end
                else begin
                    logic [OUT_BITS-1:0] e;
                    e = sb.pop_front();
                    if (draw_value !== e) begin failures++; $display("FAIL draw_value got=%h exp=%h", draw_value, e); end
                end
            end
        end
        checks++; if (valid_n != 1 || valid_at != int'(DRAW_STEPS)) begin failures++; $display("FAIL draw_latency count=%0d at=%0d exp=1/%0d", valid_n, valid_at, DRAW_STEPS); end
        checks++; if (busy_n != int'(DRAW_STEPS) + 1) begin failures++; $display("FAIL draw_busy_len got=%0d exp=%0d", busy_n, DRAW_STEPS + 1); end
        checks++; if (draw_value !== 8'h10) begin failures++; $display("FAIL draw_value_held got=%h exp=10", draw_value); end
    endtask

    task automatic test_abort();
        int valid_n;
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        tick();
        load = 1'b1; seed = 13'h0055;
        tick();
        load = 1'b0;
        checks++; if (lfsr_out !== 13'h0055) begin failures++; $display("FAIL abort_seed got=%h exp=0055", lfsr_out); end
        checks++; if (draw_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", draw_busy); end
        valid_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (draw_valid) valid_n++;
        end
        checks++; if (valid_n != 0) begin failures++; $display("FAIL abort_no_valid got=%0d exp=0", valid_n); end
        checks++; if (draw_value !== 8'h10 || lfsr_out !== 13'h0055) begin failures++; $display("FAIL abort_hold value=%h lfsr=%h exp=10/0055", draw_value, lfsr_out); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] m;
        int valid_n;
        int first_at;
        int second_at;
        load = 1'b1; seed = 13'h1234;
        tick();
        load = 1'b0;
        m = 13'h1234;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < int'(DRAW_STEPS); i++) m = model_step(m);
            sb.push_back(m[OUT_BITS-1:0]);
        end
        draw_req = 1'b1;
        valid_n = 0; first_at = -1; second_at = -1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (draw_valid) begin
                valid_n++;
                if (valid_n == 1) first_at = i;
                if (valid_n == 2) begin second_at = i; draw_req = 1'b0; end
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL b2b_unexpected_valid at=%0d exp=none", i); end
                else begin
                    logic [OUT_BITS-1:0] e;
                    e = sb.pop_front();
                    if (draw_value !== e) begin failures++; $display("FAIL b2b_value_%0d got=%h exp=%h", valid_n, draw_value, e); end
                end
            end
        end
        draw_req = 1'b0;
        checks++; if (valid_n != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", valid_n); end
        checks++; if (second_at - first_at != int'(DRAW_STEPS) + 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", second_at - first_at, DRAW_STEPS + 2); end
        checks++; if (lfsr_out !== m) begin failures++; $display("FAIL b2b_state got=%h exp=%h", lfsr_out, m); end
    endtask

    task automatic test_async_reset();
        int valid_n;
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (lfsr_out !== 13'h1FFF) begin failures++; $display("FAIL async_rst_lfsr got=%h exp=1fff", lfsr_out); end
        checks++; if (draw_busy !== 1'b0 || draw_valid !== 1'b0 || draw_value !== 8'h00) begin failures++; $display("FAIL async_rst_flags busy=%b valid=%b value=%h exp=0/0/00", draw_busy, draw_valid, draw_value); end
        tick(); tick();
        rst = 1'b0;
        valid_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (draw_valid) valid_n++;
        end
        checks++; if (valid_n != 0) begin failures++; $display("FAIL async_rst_no_valid got=%0d exp=0", valid_n); end
        checks++; if (lfsr_out !== 13'h1FFF) begin failures++; $display("FAIL async_rst_hold got=%h exp=1fff", lfsr_out); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    endtask

`ifdef LFSR_PERIOD_CHECK_EN
    task automatic test_period();
        int wraps;
        int first_at;
        int second_at;
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1;
        wraps = 0; first_at = -1; second_at = -1;
        for (int i = 1; i <= 16390; i++) begin
            tick();
            if (period_wrap) begin
                wraps++;
                if (wraps == 1) first_at = i;
                if (wraps == 2) second_at = i;
            end
        end
        en = 1'b0;
        checks++; if (wraps != 2) begin failures++; $display("FAIL period_count got=%0d exp=2", wraps); end
        checks++; if (first_at != 8191 || second_at != 16382) begin failures++; $display("FAIL period_at got=%0d,%0d exp=8191,16382", first_at, second_at); end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_load_lockup();
        test_draw();
        test_abort();
        test_back_to_back();
        test_async_reset();
`ifdef LFSR_PERIOD_CHECK_EN
        test_period();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
